// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory / CPU-control outputs of the program loader.
// The master modport is the loader; the slave modport is the surrounding system.
interface program_loader_if #(
  parameter int unsigned XLEN = 32
);
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            imem_write_enable;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_data;
  logic            cpu_reset;
  logic            load_done;
  logic            error;

  modport master (
    input  rx_data, rx_valid,
    output imem_write_enable, imem_addr, imem_data, cpu_reset, load_done, error
  );

  modport slave (
    output rx_data, rx_valid,
    input  imem_write_enable, imem_addr, imem_data, cpu_reset, load_done, error
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: assembles a little-endian UART byte stream into instruction words,
// writes them to instruction memory and releases the CPU reset once the image is in.
module program_loader #(
  parameter int unsigned MEMORY_DEPTH   = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned XLEN           = 32
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  program_loader_if.master  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_HEADER = 2'd0,
    S_DATA   = 2'd1,
    S_DONE   = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [23:0]     shift_q, shift_d;
  logic [XLEN-1:0] count_q, count_d;
  logic [XLEN-1:0] index_q, index_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            cpu_reset_q, cpu_reset_d;
  logic            load_done_q, load_done_d;
  logic            error_q, error_d;

  logic            accept;
  logic            last_byte;
  logic            counting;
  logic            expire;
  logic [31:0]     assembled;

  // Earlier bytes sit in shift_q, so the incoming byte lands in the top lane.
  assign accept    = bus.rx_valid && (state_q == S_HEADER || state_q == S_DATA);
  assign assembled = {bus.rx_data, shift_q};
  assign last_byte = accept && (bcnt_q == 2'd3);
  assign counting  = (state_q == S_DATA) || (state_q == S_HEADER && bcnt_q != 2'd0);
  assign expire    = counting && !accept && (tmo_q >= TW'(TIMEOUT_CYCLES - 1));

  // State and output registers
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= S_HEADER;
      bcnt_q      <= '0;
      shift_q     <= '0;
      count_q     <= '0;
      index_q     <= '0;
      tmo_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cpu_reset_q <= 1'b1;
      load_done_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      index_q     <= index_d;
      tmo_q       <= tmo_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cpu_reset_q <= cpu_reset_d;
      load_done_q <= load_done_d;
      error_q     <= error_d;
    end
  end

  // Next state; completion waits for the final write strobe to have been issued
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HEADER: begin
        if (last_byte) begin
          if (assembled == 32'd0)                   state_d = S_DONE;
          else if (assembled > 32'(MEMORY_DEPTH))   state_d = S_ERROR;
          else                                      state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (expire)                                          state_d = S_ERROR;
        else if (we_q && index_q == count_q - XLEN'(1))      state_d = S_DONE;
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_HEADER;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    count_d     = count_q;
    index_d     = index_q;
    tmo_d       = tmo_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    cpu_reset_d = (state_d != S_DONE);
    load_done_d = (state_d == S_DONE);
    error_d     = (state_d == S_ERROR);

    if (accept) begin
      shift_d = assembled[31:8];
      bcnt_d  = 2'(bcnt_q + 2'd1);
      tmo_d   = '0;
    end else if (counting && tmo_q < TW'(TIMEOUT_CYCLES)) begin
      tmo_d = TW'(tmo_q + TW'(1));
    end

    // A stale partial header is dropped so the next byte starts a fresh count.
    if (state_q == S_HEADER && expire) begin
      bcnt_d = '0;
      tmo_d  = '0;
    end

    if (state_q == S_HEADER && last_byte) begin
      count_d = XLEN'(assembled);
      index_d = '0;
    end

    if (state_q == S_DATA && last_byte) begin
      we_d   = 1'b1;
      addr_d = {index_q[XLEN-3:0], 2'b00};
      data_d = XLEN'(assembled);
    end

    if (state_q == S_DATA && we_q) begin
      index_d = XLEN'(index_q + XLEN'(1));
    end
  end

  assign bus.imem_write_enable = we_q;
  assign bus.imem_addr         = addr_q;
  assign bus.imem_data         = data_q;
  assign bus.cpu_reset         = cpu_reset_q;
  assign bus.load_done         = load_done_q;
  assign bus.error             = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: stimulus queues expected memory
// writes, an independent negedge monitor pops and compares every write strobe.
module tb_program_loader;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned TMO   = 16;

  logic i_Clock;
  logic i_Reset;

  program_loader_if #(.XLEN(XLEN)) bus ();

  program_loader #(
    .MEMORY_DEPTH   (DEPTH),
    .TIMEOUT_CYCLES (TMO),
    .XLEN           (XLEN)
  ) dut (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          total;
  int          bad;
  int          writes_seen;
  wr_t         exp_q[$];
  logic [31:0] img[$];

  initial begin
    i_Clock = 1'b0;
    forever #5 i_Clock = ~i_Clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation
  always @(negedge i_Clock) begin
    if (!i_Reset && bus.imem_write_enable === 1'b1) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: actual addr=%h data=%h required no write",
                 bus.imem_addr, bus.imem_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", bus.imem_addr, e.addr);
        check("write_data", bus.imem_data, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge i_Clock);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_Clock);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) begin
      idle($urandom_range(max_gap, 0));
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic do_reset();
    i_Reset      = 1'b1;
    bus.rx_valid = 1'b0;
    #1;
    check("rst_we",        32'(bus.imem_write_enable), 32'd0);
    check("rst_addr",      bus.imem_addr,              32'd0);
    check("rst_data",      bus.imem_data,              32'd0);
    check("rst_cpu_reset", 32'(bus.cpu_reset),         32'd1);
    check("rst_load_done", 32'(bus.load_done),         32'd0);
    check("rst_error",     32'(bus.error),             32'd0);
    @(posedge i_Clock);
    #1;
    i_Reset = 1'b0;
  endtask

  function automatic void expect_image();
    for (int i = 0; i < img.size(); i++) begin
      wr_t e;
      e.addr = 32'(i * 4);
      e.data = img[i];
      exp_q.push_back(e);
    end
  endfunction

  // Streams count + words, then checks strobe/done timing and the write count
  task automatic load_image(input int max_gap);
    int          ws0;
    logic [31:0] n;
    n   = 32'(img.size());
    ws0 = writes_seen;
    expect_image();
    send_word(n, max_gap);
    for (int i = 0; i < img.size(); i++) send_word(img[i], max_gap);
    @(negedge i_Clock);
    if (n != 0) begin
      check("last_strobe_cpu_reset", 32'(bus.cpu_reset), 32'd1);
      check("last_strobe_load_done", 32'(bus.load_done), 32'd0);
      @(negedge i_Clock);
    end
    check("done_load_done", 32'(bus.load_done), 32'd1);
    check("done_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    check("done_error",     32'(bus.error),     32'd0);
    check("write_count",    32'(writes_seen - ws0), n);
    check("pending_writes", 32'(exp_q.size()),  32'd0);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    writes_seen  = 0;
    i_Reset      = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    // Directed two-word image, then bytes after completion must be ignored
    do_reset();
    img = '{32'h0010_0513, 32'h0000_006F};
    load_image(0);
    for (int i = 0; i < 10; i++) begin
      idle($urandom_range(2, 0));
      send_byte(8'($urandom));
    end
    idle(2);
    check("after_done_load_done", 32'(bus.load_done), 32'd1);
    check("after_done_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    check("after_done_error",     32'(bus.error),     32'd0);
    check("after_done_addr",      bus.imem_addr,      32'h4);
    check("after_done_data",      bus.imem_data,      32'h0000_006F);

    // Empty image completes right after the count
    do_reset();
    img.delete();
    load_image(2);

    // Oversized image is rejected and stays rejected
    do_reset();
    send_word(32'd1025, 0);
    @(negedge i_Clock);
    check("oversize_error",     32'(bus.error),     32'd1);
    check("oversize_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("oversize_load_done", 32'(bus.load_done), 32'd0);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom));
    idle(2);
    check("oversize_error_held", 32'(bus.error),     32'd1);
    check("oversize_done_held",  32'(bus.load_done), 32'd0);

    // Largest legal image
    do_reset();
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
    load_image(0);

    // Header resync after a stalled partial count
    do_reset();
    send_byte(8'hFF);
    send_byte(8'hFF);
    idle(TMO);
    img = '{$urandom};
    load_image(1);

    // One idle cycle short of the limit mid-word is tolerated
    do_reset();
    img = '{$urandom};
    expect_image();
    send_word(32'd1, 0);
    send_byte(img[0][7:0]);
    send_byte(img[0][15:8]);
    idle(TMO - 1);
    send_byte(img[0][23:16]);
    send_byte(img[0][31:24]);
    idle(2);
    check("near_timeout_done",  32'(bus.load_done), 32'd1);
    check("near_timeout_error", 32'(bus.error),     32'd0);

    // Stall mid-word reaches the limit
    do_reset();
    send_word(32'd1, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    idle(TMO);
    check("stall_error",     32'(bus.error),     32'd1);
    check("stall_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("stall_load_done", 32'(bus.load_done), 32'd0);

    // Stall between words also errors
    do_reset();
    img = '{$urandom};
    expect_image();
    send_word(32'd2, 0);
    send_word(img[0], 0);
    idle(TMO);
    check("word_gap_error",   32'(bus.error),    32'd1);
    check("word_gap_pending", 32'(exp_q.size()), 32'd0);

    // Reset after 5 of 8 data bytes, then a fresh one-word image
    do_reset();
    img = '{$urandom, $urandom};
    begin
      wr_t e;
      e.addr = 32'h0;
      e.data = img[0];
      exp_q.push_back(e);
    end
    send_word(32'd2, 0);
    send_word(img[0], 0);
    send_byte(img[1][7:0]);
    do_reset();
    img = '{$urandom};
    load_image(1);

    // Randomized images with random inter-byte gaps
    for (int t = 0; t < 6; t++) begin
      int n;
      do_reset();
      img.delete();
      n = $urandom_range(8, 1);
      for (int i = 0; i < n; i++) img.push_back($urandom);
      load_image(3);
    end

    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader that sits directly upstream of the CPU's instruction memory.
- Takes a byte stream from the UART receiver, assembles little-endian 32-bit instruction words and writes them to instruction memory through a dedicated write port.
- Holds the CPU core in reset until the image is fully loaded, then releases it so the core starts fetching at PC 0.

Parameters:
- MEMORY_DEPTH, 1024, instruction memory depth in words; a larger image is rejected.
- TIMEOUT_CYCLES, 100000, idle clock cycles allowed between bytes of a partial header or word before timeout action.
- XLEN, 32, data/address width, from cpu_core_params.vh.

Ports:
- i_Clock  input  1  system clock, all state changes on rising edge
- i_Reset  input  1  asynchronous, active-high reset
- i_Rx_Data  input  8  received byte
- i_Rx_Valid  input  1  one-cycle strobe, i_Rx_Data valid; no backpressure
- o_Imem_Write_Enable  output  1  one-cycle instruction memory write strobe
- o_Imem_Addr  output  XLEN  byte address of write, word aligned
- o_Imem_Data  output  XLEN  instruction word to write
- o_Cpu_Reset  output  1  holds the CPU core in reset while high
- o_Load_Done  output  1  image loaded, CPU released
- o_Error  output  1  load failed, sticky until i_Reset

Behaviour:
- Reset (async, i_Reset=1):
  - state=S_HEADER; byte/word counters and timeout counter cleared.
  - Outputs: o_Cpu_Reset=1, o_Imem_Write_Enable=0, o_Imem_Addr=0, o_Imem_Data=0, o_Load_Done=0, o_Error=0.
- All outputs are registered.
- Stream format: 4-byte little-endian word count N, then N×4 bytes, each word little-endian (first byte → bits [7:0]).
- S_HEADER:
  - Collects 4 count bytes.
  - On the 4th byte: N=0 → S_DONE; N>MEMORY_DEPTH → S_ERROR; else → S_DATA with word index 0.
- S_DATA:
  - Shifts bytes into the word assembler.
  - The cycle after the 4th byte of a word is accepted: o_Imem_Write_Enable=1 for exactly one cycle, o_Imem_Addr=index×4, o_Imem_Data={b3,b2,b1,b0}; then index increments.
  - After the write of word N-1 → S_DONE, entered the cycle after that write strobe.
  - A byte arriving in the same cycle as a write strobe is accepted normally as byte 0 of the next word.
- S_DONE:
  - o_Cpu_Reset=0 and o_Load_Done=1, both change in the same cycle.
  - Further bytes are ignored; no writes occur.
  - The state is held until i_Reset.
- S_ERROR:
  - o_Error=1, o_Cpu_Reset=1, o_Load_Done=0.
  - Bytes are ignored; the state is held until i_Reset.
- Timeout counter:
  - Clears on every accepted byte; increments otherwise, saturating at TIMEOUT_CYCLES.
  - Counts only while a header or word is partially received (1–3 bytes) or while in S_DATA.
  - Reaching TIMEOUT_CYCLES in S_HEADER: discard the partial header and stay in S_HEADER with the byte count at 0 (resync); no error.
  - Reaching TIMEOUT_CYCLES in S_DATA → S_ERROR.
  - In S_DATA with 0 bytes of the current word received, the counter still runs, so a stalled image errors.
- Reset mid-load: all state is discarded and the loader restarts in S_HEADER. Memory contents already written are not cleared.
- The word index is XLEN wide; the address is index<<2. No wrap is possible because N≤MEMORY_DEPTH is enforced.
- i_Rx_Valid is never high for two consecutive bytes faster than one per cycle; at most one byte per cycle is accepted.

Test Plan:
- Stream 02 00 00 00, 13 05 10 00, 6F 00 00 00 → writes addr 0x0 data 0x00100513 and addr 0x4 data 0x0000006F. Exactly two write strobes. o_Cpu_Reset falls and o_Load_Done rises one cycle after the second strobe.
- Stream 00 00 00 00 → no writes; o_Load_Done=1 and o_Cpu_Reset=0 the cycle after the 4th byte.
- Count 01 04 00 00 (N=1025) → o_Error=1, o_Cpu_Reset stays 1, and subsequent bytes produce no writes.
- Timeout cases (TIMEOUT_CYCLES=16):
  - Send 2 header bytes, idle 16 cycles, then 01 00 00 00 + one word → a normal single-word load (resync).
  - Stall 16 cycles mid-word → o_Error=1.
- Assert i_Reset for 1 cycle after 5 of 8 data bytes, then send a full 1-word image → outputs return to reset values immediately, then a single write to addr 0x0 and o_Load_Done=1.
- After o_Load_Done, send 10 random bytes → no write strobes and no output changes.
